// File: rtl/depth_activation.sv
// depth_activation: bias add, int8 requant and activation for the depthwise path.
// Ports: clk/rst, start + cfg_* (latched on start), in_valid/in_ready with
// acc_data/bias_data, out_valid/out_ready with act_data, activation_done
// (write strobe), out_index (element being written) and layer_done (pulse
// after the last element). Macro DEPTH_ACT_HSWISH_EN enables h-swish in mode 3;
// without it, mode 3 is ReLU6 and cfg_recip6 is ignored.
module depth_activation #(
  parameter int ACC_W   = 24,
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         cfg_mode,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [DATA_W-1:0]  cfg_three_q,
  input  logic [DATA_W-1:0]  cfg_six_q,
  input  logic [15:0]        cfg_recip6,
  input  logic [CNT_W-1:0]   cfg_count_max,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   acc_data,
  input  logic [ACC_W-1:0]   bias_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  act_data,
  output logic               activation_done,
  output logic [CNT_W-1:0]   out_index,
  output logic               layer_done
);

  typedef enum logic [1:0] {
    M_LIN   = 2'd0,
    M_RELU  = 2'd1,
    M_RELU6 = 2'd2,
    M_HSW   = 2'd3
  } mode_e;

  localparam int SW = ACC_W + 1;
  localparam int RW = 1 << SHIFT_W;
  // wide enough for the rounding constant at the largest shift
  localparam int EW = ((SW > RW) ? SW : RW) + 1;
  localparam int QW = DATA_W + 2;
  localparam logic signed [EW-1:0] L_MAX = EW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [EW-1:0] L_MIN = ~L_MAX;
  localparam logic signed [EW-1:0] L_ONE = EW'(1);

  mode_e               r_mode;
  logic [SHIFT_W-1:0]  r_shift;
  logic [DATA_W-1:0]   r_six;
  logic [CNT_W-1:0]    r_cmax;
  logic                r_v1, r_v2, r_v3;
  logic signed [SW-1:0]     r_sum;
  logic signed [DATA_W-1:0] r_q, r_act;
  logic [CNT_W-1:0]    r_idx;
  logic                r_ld;

  logic                  w_stall, w_done;
  logic signed [SW-1:0]  w_sum;
  logic [SHIFT_W-1:0]    w_sm1;
  logic signed [EW-1:0]  w_ext, w_rnd, w_tmp, w_shd;
  logic signed [DATA_W-1:0] w_qsat;
  logic signed [QW-1:0]  w_qx, w_six, w_relu, w_relu6, w_y;
  logic                  w_unused;

  assign w_stall         = r_v3 & ~out_ready;
  assign w_done          = r_v3 & out_ready;
  assign in_ready        = ~w_stall & ~start;
  assign out_valid       = r_v3;
  assign act_data        = r_act;
  assign activation_done = w_done;
  assign out_index       = r_idx;
  assign layer_done      = r_ld;

  assign w_sum = SW'($signed(acc_data)) + SW'($signed(bias_data));

  // round-half-up: add 2^(shift-1) before the arithmetic shift
  assign w_sm1  = r_shift - SHIFT_W'(1);
  assign w_ext  = EW'(r_sum);
  assign w_rnd  = (r_shift == '0) ? '0 : (L_ONE << w_sm1);
  assign w_tmp  = w_ext + w_rnd;
  assign w_shd  = w_tmp >>> r_shift;
  assign w_qsat = (w_shd > L_MAX) ? L_MAX[DATA_W-1:0] :
                  (w_shd < L_MIN) ? L_MIN[DATA_W-1:0] :
                  w_shd[DATA_W-1:0];

  assign w_qx    = QW'(r_q);
  assign w_six   = QW'(r_six);
  assign w_relu  = w_qx[QW-1] ? '0 : w_qx;
  assign w_relu6 = (w_relu > w_six) ? w_six : w_relu;

`ifdef DEPTH_ACT_HSWISH_EN
  localparam int PW = 2 * DATA_W;
  localparam int HW = PW + 17;
  localparam logic signed [HW-1:0] H_MAX  = HW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [HW-1:0] H_MIN  = ~H_MAX;
  localparam logic signed [HW-1:0] H_HALF = HW'(32768);

  logic [DATA_W-1:0]        r_three;
  logic [15:0]              r_recip;
  logic signed [QW-1:0]     w_thr, w_qt, w_t, w_hsw;
  logic signed [PW-1:0]     w_p;
  logic signed [HW-1:0]     w_pr, w_hsh;
  logic signed [DATA_W-1:0] w_hsat;

  assign w_thr  = QW'(r_three);
  assign w_qt   = w_qx + w_thr;
  assign w_t    = w_qt[QW-1] ? '0 : ((w_qt > w_six) ? w_six : w_qt);
  assign w_p    = PW'(w_qx) * PW'(w_t);
  // recip6 is a Q16 reciprocal of six_q, so >>>16 completes the divide
  assign w_pr   = HW'(w_p) * $signed(HW'(r_recip));
  assign w_hsh  = (w_pr + H_HALF) >>> 16;
  assign w_hsat = (w_hsh > H_MAX) ? H_MAX[DATA_W-1:0] :
                  (w_hsh < H_MIN) ? H_MIN[DATA_W-1:0] :
                  w_hsh[DATA_W-1:0];
  assign w_hsw  = QW'(w_hsat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_three <= '0;
      r_recip <= '0;
    end else if (start) begin
      r_three <= cfg_three_q;
      r_recip <= cfg_recip6;
    end
  end

  assign w_unused = ^w_y[QW-1:DATA_W];
`else
  assign w_unused = ^{w_y[QW-1:DATA_W], cfg_three_q, cfg_recip6};
`endif

  always_comb begin
    w_y = w_qx;
    unique case (r_mode)
      M_LIN:   w_y = w_qx;
      M_RELU:  w_y = w_relu;
      M_RELU6: w_y = w_relu6;
      M_HSW: begin
`ifdef DEPTH_ACT_HSWISH_EN
        w_y = w_hsw;
`else
        w_y = w_relu6;
`endif
      end
      default: w_y = w_qx;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= M_LIN;
      r_shift <= '0;
      r_six   <= '0;
      r_cmax  <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_sum   <= '0;
      r_q     <= '0;
      r_act   <= '0;
      r_idx   <= '0;
      r_ld    <= 1'b0;
    end else if (start) begin
      r_mode  <= mode_e'(cfg_mode);
      r_shift <= cfg_shift;
      r_six   <= cfg_six_q;
      r_cmax  <= cfg_count_max;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_idx   <= '0;
      r_ld    <= 1'b0;
    end else begin
      r_ld <= 1'b0;
      if (w_done) begin
        if (r_idx == (r_cmax - CNT_W'(1))) begin
          r_idx <= '0;
          r_ld  <= 1'b1;
        end else begin
          r_idx <= r_idx + CNT_W'(1);
        end
      end
      if (!w_stall) begin
        r_v1 <= in_valid;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
        if (in_valid) r_sum <= w_sum;
        if (r_v1)     r_q   <= w_qsat;
        if (r_v2)     r_act <= w_y[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_depth_activation.sv
// tb_depth_activation: vector table, directed corner sequences and random
// streams checked against an arithmetic reference model with a scoreboard.
module tb_depth_activation;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cfg_mode;
  logic [4:0]  cfg_shift;
  logic [7:0]  cfg_three_q, cfg_six_q;
  logic [15:0] cfg_recip6;
  logic [12:0] cfg_count_max;
  logic        in_valid, in_ready;
  logic [23:0] acc_data, bias_data;
  logic        out_ready, out_valid;
  logic [7:0]  act_data;
  logic        activation_done;
  logic [12:0] out_index;
  logic        layer_done;

  depth_activation dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
    .cfg_three_q(cfg_three_q), .cfg_six_q(cfg_six_q),
    .cfg_recip6(cfg_recip6), .cfg_count_max(cfg_count_max),
    .in_valid(in_valid), .in_ready(in_ready),
    .acc_data(acc_data), .bias_data(bias_data),
    .out_ready(out_ready), .out_valid(out_valid),
    .act_data(act_data), .activation_done(activation_done),
    .out_index(out_index), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int md; int sh; int th; int sx; int rc;
    int acc; int bias; int e_hs; int e_bs;
  } vec_t;

  vec_t vt[18];

  int errors = 0;
  int checks = 0;
  int m_mode, m_shift, m_thr, m_six, m_rcp, m_cmax;
  longint expq[$];
  int     cycq[$];
  int     exp_idx;
  bit     exp_ld;
  bit     prev_stall;
  logic [7:0]  prev_act;
  logic [12:0] prev_idx;
  int     cyc = 0;
  int     outs = 0;
  int     accepted = 0;
  longint last_act;
  bit     lat_chk = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint sat8(input longint v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic longint clampv(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic longint model(input int a, input int b);
    longint s, q, t, p, y;
    s = longint'(a) + longint'(b);
    if (m_shift == 0) q = s;
    else q = (s + (longint'(1) <<< (m_shift - 1))) >>> m_shift;
    q = sat8(q);
    case (m_mode)
      0: y = q;
      1: y = (q < 0) ? 0 : q;
      2: y = clampv(q, 0, m_six);
      default: begin
`ifdef DEPTH_ACT_HSWISH_EN
        t = clampv(q + m_thr, 0, m_six);
        p = q * t;
        y = sat8((p * m_rcp + 32768) >>> 16);
`else
        t = 0;
        p = 0;
        y = clampv(q, 0, m_six);
`endif
      end
    endcase
    return y;
  endfunction

  function automatic int rnd_val();
    int r;
    r = $urandom;
    return r >>> $urandom_range(8, 22);
  endfunction

  task automatic step(input bit iv, input int a, input int b, input bit ordy);
    @(posedge clk);
    #1;
    start     = 1'b0;
    in_valid  = iv;
    acc_data  = a[23:0];
    bias_data = b[23:0];
    out_ready = ordy;
    cfg_mode      = 2'($urandom);
    cfg_shift     = 5'($urandom);
    cfg_three_q   = 8'($urandom);
    cfg_six_q     = 8'($urandom);
    cfg_recip6    = 16'($urandom);
    cfg_count_max = 13'($urandom);
    @(negedge clk);
    cyc++;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    check("act_done", activation_done, out_valid && out_ready);
    check("layer_done", layer_done, exp_ld);
    exp_ld = 0;
    if (prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", act_data, prev_act);
      check("hold_index", out_index, prev_idx);
    end
    if (in_valid && in_ready) begin
      expq.push_back(model(a, b));
      cycq.push_back(cyc);
      accepted++;
    end
    if (out_valid && out_ready) begin
      outs++;
      last_act = longint'($signed(act_data));
      if (expq.size() == 0) begin
        check("spurious_out", 1, 0);
      end else begin
        longint e;
        int c;
        e = expq.pop_front();
        c = cycq.pop_front();
        check("act_data", longint'($signed(act_data)), e);
        if (lat_chk) check("latency", cyc - c, 3);
      end
      check("out_index", out_index, exp_idx);
      if (exp_idx == m_cmax - 1) begin
        exp_idx = 0;
        exp_ld  = 1;
      end else begin
        exp_idx++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_act   = act_data;
    prev_idx   = out_index;
  endtask

  task automatic do_start(input int md, input int sh, input int th,
                          input int sx, input int rc, input int cm);
    @(posedge clk);
    #1;
    start         = 1'b1;
    cfg_mode      = md[1:0];
    cfg_shift     = sh[4:0];
    cfg_three_q   = th[7:0];
    cfg_six_q     = sx[7:0];
    cfg_recip6    = rc[15:0];
    cfg_count_max = cm[12:0];
    in_valid      = 1'b1;
    acc_data      = 24'($urandom);
    bias_data     = 24'($urandom);
    out_ready     = 1'b0;
    @(negedge clk);
    cyc++;
    check("in_ready_start", in_ready, 0);
    m_mode = md; m_shift = sh; m_thr = th;
    m_six = sx; m_rcp = rc; m_cmax = cm;
    expq.delete();
    cycq.delete();
    exp_idx    = 0;
    exp_ld     = 0;
    prev_stall = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    int o, g;
    do_start(v.md, v.sh, v.th, v.sx, v.rc, 1);
    o = outs;
    step(1, v.acc, v.bias, 1);
    g = 0;
    while (outs == o && g < 10) begin
      step(0, 0, 0, 1);
      g++;
    end
    check("vec_timeout", outs - o, 1);
`ifdef DEPTH_ACT_HSWISH_EN
    check("vec", last_act, v.e_hs);
`else
    check("vec", last_act, v.e_bs);
`endif
    step(0, 0, 0, 1);
  endtask

  task automatic run_layer(input int n, input int pv, input int pr);
    int g, a0, o0, oexp;
    bit iv;
    a0 = accepted;
    o0 = outs;
    oexp = n + expq.size();
    g = 0;
    while (((accepted - a0) < n || expq.size() > 0) && g < 4000) begin
      iv = ((accepted - a0) < n) && ($urandom_range(0, 99) < pv);
      step(iv, rnd_val(), rnd_val(), $urandom_range(0, 99) < pr);
      g++;
    end
    check("drain_timeout", (g < 4000) ? 1 : 0, 1);
    step(0, 0, 0, 1);
    check("out_count", outs - o0, oexp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int o, md, sx, n;
    vt[0]  = '{0, 0,  0,  0,   0,     100,     -20,   80,   80};
    vt[1]  = '{1, 4,  0,  0,   0,   -1000,       0,    0,    0};
    vt[2]  = '{1, 4,  0,  0,   0,    1000,       8,   63,   63};
    vt[3]  = '{1, 4,  0,  0,   0,    5000,       0,  127,  127};
    vt[4]  = '{2, 0,  0, 96,   0,     120,       0,   96,   96};
    vt[5]  = '{2, 0,  0, 96,   0,      -5,       0,    0,    0};
    vt[6]  = '{2, 0,  0, 96,   0,    -300,       0,    0,    0};
    vt[7]  = '{3, 0, 48, 96, 683,      96,       0,   96,   96};
    vt[8]  = '{3, 0, 48, 96, 683,     -48,       0,    0,    0};
    vt[9]  = '{3, 0, 48, 96, 683,      24,       0,   18,   24};
    vt[10] = '{3, 0, 48, 96, 683,     -24,       0,   -6,    0};
    vt[11] = '{3, 0, 48, 96, 683,     127,       0,  127,   96};
    vt[12] = '{0, 1,  0,  0,   0,      -3,       0,   -1,   -1};
    vt[13] = '{0, 1,  0,  0,   0,       3,       0,    2,    2};
    vt[14] = '{0, 31, 0,  0,   0, 8388607, 8388607,    0,    0};
    vt[15] = '{0, 0,  0,  0,   0,-8388608,-8388608, -128, -128};
    vt[16] = '{0, 2,  0,  0,   0,      -2,       0,    0,    0};
    vt[17] = '{0, 0,  0,  0,   0,     200,     -50,  127,  127};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_mode = '0; cfg_shift = '0; cfg_three_q = '0; cfg_six_q = '0;
    cfg_recip6 = '0; cfg_count_max = '0; acc_data = '0; bias_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_act_data", act_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_layer_done", layer_done, 0);

    foreach (vt[i]) apply_vec(vt[i]);

    // 4-element layer, no stall: latency and index sequence
    do_start(0, 0, 0, 0, 0, 4);
    lat_chk = 1;
    o = outs;
    repeat (4) step(1, 100, -20, 1);
    repeat (5) step(0, 0, 0, 1);
    lat_chk = 0;
    check("l4_outs", outs - o, 4);
    check("l4_last", last_act, 80);
    check("l4_index", out_index, 0);

    // backpressure for 5 cycles with a stream in flight
    do_start(1, 2, 0, 0, 0, 10);
    repeat (3) step(1, rnd_val(), rnd_val(), 1);
    repeat (5) step(1, rnd_val(), rnd_val(), 0);
    check("bp_in_ready", in_ready, 0);
    check("bp_valid", out_valid, 1);
    run_layer(10 - expq.size() - outs + o + 4, 100, 100);

    // start with two elements in flight
    do_start(0, 0, 0, 0, 0, 8);
    step(1, 7, 0, 1);
    step(1, 9, 0, 1);
    do_start(0, 0, 0, 0, 0, 8);
    step(0, 0, 0, 1);
    check("st_valid", out_valid, 0);
    check("st_index", out_index, 0);
    o = outs;
    repeat (5) step(0, 0, 0, 1);
    check("st_drop", outs - o, 0);
    run_layer(8, 80, 80);

    // asynchronous reset with an output pending
    do_start(0, 0, 0, 0, 0, 8);
    repeat (4) step(1, rnd_val(), rnd_val(), 1);
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_index", out_index, 0);
    check("arst_data", act_data, 0);
    check("arst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    cycq.delete();
    exp_idx = 0; exp_ld = 0; prev_stall = 0;

    // random layers, random handshakes, wrap inside a stream
    for (int l = 0; l < 8; l++) begin
      md = $urandom_range(0, 3);
      sx = $urandom_range(1, 127);
      n  = $urandom_range(5, 30);
      do_start(md, ($urandom_range(0, 5) == 0) ? 31 : $urandom_range(0, 10),
               $urandom_range(0, 127), sx, (65536 + sx / 2) / sx,
               $urandom_range(1, n));
      run_layer(n, 75, 70);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
